// File: rtl/sram_read_slave.sv
// sram_read_slave: word-addressed 64-bit SRAM read responder with configurable/random latency, async active-low rst, and byte-strobed backdoor write
module sram_read_slave #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          LAT_MIN    = 1,
  parameter bit          LAT_RAND   = 1'b0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_signal,
  input  logic [63:0] read_addr,
  output logic        data_arrive,
  output logic [63:0] data_outside,
  output logic        fault,
  input  logic        wr_en,
  input  logic [63:0] wr_addr,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_strb
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;
  localparam logic [63:0] SPAN = 64'd1 << (DEPTH_LOG2 + 3);
  state_t state;
  logic [63:0] mem [2**DEPTH_LOG2];
  logic [63:0] addr_q, roff, woff;
  logic [DEPTH_LOG2-1:0] ridx, widx;
  logic rin, win;
  logic [15:0] lfsr;
  logic [7:0] cnt, cnt_ld;
  assign roff = addr_q - BASE_ADDR;
  assign woff = wr_addr - BASE_ADDR;
  assign rin = addr_q >= BASE_ADDR && roff < SPAN;
  assign win = wr_addr >= BASE_ADDR && woff < SPAN;
  assign ridx = roff[DEPTH_LOG2+2:3];
  assign widx = woff[DEPTH_LOG2+2:3];
  assign cnt_ld = 8'(LAT_MIN - 1) + (LAT_RAND ? {6'd0, lfsr[1:0]} : 8'd0);
  always_ff @(posedge clk) begin
    if (wr_en && win)
      for (int i = 0; i < 8; i++)
        if (wr_strb[i]) mem[widx][8*i +: 8] <= wr_data[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      data_arrive  <= 1'b0;
      data_outside <= '0;
      fault        <= 1'b0;
      cnt          <= '0;
      lfsr         <= LFSR_SEED;
      addr_q       <= '0;
    end else begin
      lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      data_arrive <= 1'b0;
      case (state)
        IDLE: if (read_signal) begin
          addr_q <= read_addr;
          cnt    <= cnt_ld;
          state  <= cnt_ld != 8'd0 ? WAIT : RESP;
        end
        WAIT: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= RESP;
        end
        RESP: begin
          data_arrive  <= 1'b1;
          data_outside <= rin ? mem[ridx] : '0;
          fault        <= !rin;
          state        <= DONE;
        end
        DONE: if (!read_signal) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_read_slave.sv
// tb_sram_read_slave: directed and randomized checks of sram_read_slave against a behavioural memory model
module tb_sram_read_slave;
  localparam logic [63:0] BASE = 64'h8000_0000;
  logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0;
  logic [3:0] rs = '0;
  logic [63:0] read_addr = '0, wr_addr = '0, wr_data = '0;
  logic [7:0] wr_strb = '0;
  logic da [4];
  logic [63:0] dout [4];
  logic flt [4];
  logic [63:0] mm [64];
  int checks = 0, errors = 0;
  int hist [4] = '{default: 0};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    sram_read_slave #(
      .DEPTH_LOG2(6), .BASE_ADDR(BASE),
      .LAT_MIN(g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 4 : 2),
      .LAT_RAND(g == 3), .LFSR_SEED(16'hACE1)
    ) u (
      .clk(clk), .rst(rst), .read_signal(rs[g]), .read_addr(read_addr),
      .data_arrive(da[g]), .data_outside(dout[g]), .fault(flt[g]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
    );
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic bit inr(input logic [63:0] a);
    return a >= BASE && (a - BASE) < 64'd512;
  endfunction
  function automatic logic [63:0] exp_data(input logic [63:0] a);
    logic [63:0] o = a - BASE;
    return inr(a) ? mm[o[8:3]] : 64'd0;
  endfunction
  task automatic mwrite(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] o = a - BASE;
    if (inr(a))
      for (int i = 0; i < 8; i++)
        if (s[i]) mm[o[8:3]][8*i +: 8] = d[8*i +: 8];
  endtask
  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    @(posedge clk);
    mwrite(a, d, s);
    #1 wr_en = 1'b0;
  endtask
  task automatic rd(input int k, input logic [63:0] a, input int lmin, input bit rnd, input int hold);
    logic [63:0] ed;
    logic ef;
    int lat;
    ed = exp_data(a);
    ef = !inr(a);
    @(negedge clk);
    read_addr = a; rs[k] = 1'b1;
    @(posedge clk);
    #1 read_addr = {$urandom, $urandom};
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (da[k]) break;
    end
    if (rnd) begin
      chk("lat_range", lat >= lmin && lat <= lmin + 3, 1);
      if (lat >= lmin && lat <= lmin + 3) hist[lat - lmin]++;
    end else chk("latency", lat, lmin);
    chk("data", dout[k], ed);
    chk("fault", flt[k], ef);
    @(posedge clk); #1;
    chk("pulse_end", da[k], 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("no_repeat", da[k], 0);
    end
    @(negedge clk);
    rs[k] = 1'b0;
    @(posedge clk);
  endtask
  initial begin
    logic [63:0] ed, a;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rst_arrive", da[k], 0);
      chk("rst_data", dout[k], 0);
      chk("rst_fault", flt[k], 0);
    end
    @(negedge clk) rst = 1'b1;
    wr(BASE, 64'h0000_0013_0000_0093, 8'hFF);
    rd(0, BASE + 4, 1, 0, 0);
    chk("t1_data", dout[0], 64'h0000_0013_0000_0093);
    wr(BASE + 16, {$urandom, $urandom}, 8'hFF);
    rd(1, BASE + 16, 3, 0, 5);
    rd(1, BASE + 16, 3, 0, 0);
    rd(0, 64'h7FFF_FFF8, 1, 0, 0);
    rd(1, BASE + 512, 3, 0, 0);
    wr(BASE + 24, 64'h1122_3344_5566_7788, 8'hFF);
    wr(BASE + 24, 64'hFFFF_FFFF_AABB_CCDD, 8'h0F);
    rd(0, BASE + 24, 1, 0, 0);
    chk("t4_merge", dout[0], 64'h1122_3344_AABB_CCDD);
    ed = exp_data(BASE + 24);
    @(negedge clk);
    read_addr = BASE + 24; rs[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = BASE + 24; wr_data = 64'h0BAD_F00D_DEAD_BEEF; wr_strb = 8'hFF;
    @(posedge clk);
    mwrite(BASE + 24, 64'h0BAD_F00D_DEAD_BEEF, 8'hFF);
    #1 wr_en = 1'b0;
    chk("t4_rbw_arrive", da[1], 1);
    chk("t4_rbw_data", dout[1], ed);
    @(negedge clk) rs[1] = 1'b0;
    @(posedge clk);
    rd(1, BASE + 24, 3, 0, 0);
    wr(BASE + 8, {$urandom, $urandom} | 64'd1, 8'hFF);
    rd(2, BASE + 8, 4, 0, 0);
    @(negedge clk);
    read_addr = BASE + 8; rs[2] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; rs[2] = 1'b0;
    #1;
    chk("t5_arrive", da[2], 0);
    chk("t5_data", dout[2], 0);
    chk("t5_fault", flt[2], 0);
    @(negedge clk) rst = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("t5_silent", da[2], 0);
    end
    rd(2, BASE + 8, 4, 0, 0);
    for (int i = 0; i < 64; i++) wr(BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF);
    for (int n = 0; n < 200; n++) begin
      if (n % 16 == 7) wr(BASE + 64'($urandom_range(0, 511)), {$urandom, $urandom}, 8'($urandom));
      a = (n % 25 == 3) ? BASE + 64'd512 + 64'($urandom_range(0, 4095)) : BASE + 64'($urandom_range(0, 511));
      rd(3, a, 2, 1, 0);
    end
    for (int j = 0; j < 4; j++) chk("lat_seen", hist[j] > 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_read_slave.md
Name: sram_read_slave

Overview:
- Memory-side responder for the instruction/data read arbiter's downstream port (read_signal / read_addr / data_arrive / data_outside).
- Holds a word-addressed 64-bit SRAM array and answers each read request after a configurable, optionally randomized, latency.
- Serves as the simulation memory for the fetch path.
- Also provides a byte-strobed backdoor write port for program loading and data stores.

Parameters:
- DEPTH_LOG2, 12: array holds 2^DEPTH_LOG2 64-bit words.
- BASE_ADDR, 64'h8000_0000: byte address of word 0.
- LAT_MIN, 1: minimum response latency in cycles; must be >= 1.
- LAT_RAND, 0: 1 adds a random 0..3 extra cycles per request.
- LFSR_SEED, 16'hACE1: reset value of the latency LFSR; must be nonzero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- read_signal  in  1  read request, level. Held high with read_addr stable until data_arrive.
- read_addr  in  64  byte address of the read.
- data_arrive  out  1  one-cycle response pulse.
- data_outside  out  64  read data; valid while data_arrive=1.
- fault  out  1  out-of-range flag; qualified by data_arrive.
- wr_en  in  1  backdoor write enable.
- wr_addr  in  64  backdoor byte address.
- wr_data  in  64  backdoor write data.
- wr_strb  in  8  byte enables; bit i covers wr_data[8i+7:8i].

Behaviour:
- **Reset (rst=0, async):**
  - State goes to IDLE.
  - data_arrive=0, data_outside=0, fault=0, latency counter=0, LFSR=LFSR_SEED.
  - Array contents are not reset.
  - Reset mid-request abandons the request silently; no data_arrive is produced afterwards.
- **States:** IDLE, WAIT, RESP, DONE.
- **IDLE:**
  - read_signal=1 at edge N: capture read_addr.
  - Load cnt = LAT_MIN-1 + (LAT_RAND ? lfsr[1:0] : 0).
  - Next state is WAIT if cnt != 0, else RESP.
- **WAIT:** cnt decrements each edge; when cnt==1 the next state is RESP.
- **RESP entry edge (edge N+L, L = LAT_MIN + extra):**
  - Array is read and the result registered into data_outside and fault.
  - data_arrive=1 for exactly the cycle between edges N+L and N+L+1.
- **RESP:** always goes to DONE on the next edge; data_arrive returns to 0.
- **DONE:**
  - Stay while read_signal=1. This guarantees one response per request level.
  - Go to IDLE on the first edge where read_signal=0.
  - Back-to-back requests therefore need read_signal low for at least one sampled edge.
- **Output hold:** data_outside and fault keep their last response value until the next RESP entry edge.
- **Address map:**
  - off = addr - BASE_ADDR, 64-bit unsigned; idx = off[DEPTH_LOG2+2:3].
  - In range iff addr >= BASE_ADDR and off[63:DEPTH_LOG2+3]==0.
  - addr[2:0] is ignored: reads are aligned down to the 8-byte word, no fault.
  - Out-of-range read: data_outside=0, fault=1, with normal latency.
- **Backdoor write:**
  - Takes effect at any edge with wr_en=1, in any state, independent of reads.
  - Bytes with wr_strb[i]=1 are written; other bytes are kept.
  - Out-of-range writes are dropped silently.
  - A write to the same word on the RESP entry edge is not visible in that response (read-before-write). Writes on earlier edges are visible.
- **LFSR:**
  - 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle out of reset.
  - Only lfsr[1:0] at the capture edge matters.
- **Request changes:**
  - read_addr changes after capture are ignored.
  - read_signal dropping during WAIT does not cancel: the response is still delivered, then DONE returns to IDLE immediately.

Test Plan:
1. LAT_MIN=1, LAT_RAND=0; backdoor write 64'h0000_0013_0000_0093 at 0x8000_0000 with wr_strb=8'hFF; raise read_signal with read_addr=0x8000_0004 at edge N -> data_arrive high only between edges N+1 and N+2, data_outside=64'h0000_0013_0000_0093, fault=0.
2. LAT_MIN=3; read 0x8000_0010 -> data_arrive exactly 3 edges after capture; read_signal held high 5 more cycles produces no second pulse; drop for 1 cycle then re-raise -> second response 3 edges later.
3. Out of range: read 0x7FFF_FFF8, then 0x8000_0000 + 2^(DEPTH_LOG2+3) -> each gives data_arrive with data_outside=0, fault=1.
4. Partial write: word = 64'h1122_3344_5566_7788, then wr_strb=8'h0F with wr_data=64'hFFFF_FFFF_AABB_CCDD -> read returns 64'h1122_3344_AABB_CCDD; write on the RESP entry edge -> response shows the old value.
5. Reset mid-request: LAT_MIN=4, assert rst=0 two cycles after capture -> outputs 0 immediately; after release with read_signal=0, no data_arrive ever appears; array contents are preserved.
6. LAT_RAND=1: 200 sequential requests -> every latency falls in LAT_MIN..LAT_MIN+3, all four values occur, and each data value matches the golden model.
